// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the bit-serial calculator datapath.
//   calc_state_e        : sequencer state encoding (IDLE, RUN, DONE)
//   CALC_WIDTH_DEFAULT  : default operand/result width
//   calc_cnt_width()    : width of the bit counter for a given operand width
// ---------------------------------------------------------------------------
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } calc_state_e;

  localparam int CALC_WIDTH_DEFAULT = 8;

  // Counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
  // The floor of 1 keeps the vector legal for the smallest width.
  function automatic int calc_cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_add_sequencer_if.sv
// ---------------------------------------------------------------------------
// serial_add_sequencer_if
// Operand/result handshake bundle for serial_add_sequencer.
//   in_valid/in_ready   : operand handshake (producer -> sequencer)
//   in_a, in_b          : WIDTH-bit operands
//   in_sub              : subtract select (only with SERIAL_SUB_EN)
//   out_valid/out_ready : result handshake (sequencer -> consumer)
//   out_sum             : WIDTH-bit result
//   out_cout, out_ovf   : carry out of MSB, signed overflow
// Modports: master = operand producer / result consumer, slave = sequencer.
// Optional feature macro: SERIAL_SUB_EN
// ---------------------------------------------------------------------------
interface serial_add_sequencer_if
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH_DEFAULT
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
`ifdef SERIAL_SUB_EN
  logic             in_sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

`ifdef SERIAL_SUB_EN
  modport master (
    output in_valid, in_a, in_b, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
`else
  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
`endif

endinterface

// File: rtl/serial_add_sequencer_bit_cell.sv
// ---------------------------------------------------------------------------
// serial_bit_cell
// Combinational one-bit full-adder cell used by the serial sequencer.
//   i_a, i_b : operand bits
//   i_c      : carry in
//   o_s      : sum bit
//   o_co     : carry out
// ---------------------------------------------------------------------------
module serial_bit_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_co
);

  logic w_p;

  assign w_p  = i_a ^ i_b;
  assign o_s  = w_p ^ i_c;
  assign o_co = (i_a & i_b) | (w_p & i_c);

endmodule

// File: rtl/serial_add_sequencer.sv
// ---------------------------------------------------------------------------
// serial_add_sequencer
// Bit-serial add (optionally subtract) controller. Operands are accepted in
// IDLE, shifted LSB-first through serial_bit_cell for WIDTH cycles in RUN,
// and the result is held in DONE until the consumer takes it.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : serial_add_sequencer_if.slave (operand/result handshakes)
// Optional feature macro: SERIAL_SUB_EN (adds in_sub, A-B via A+~B+1)
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// RUN   | one bit pair per cycle through the adder cell
// DONE  | out_valid high, result held until out_ready
// ---------------------------------------------------------------------------
module serial_add_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_add_sequencer_if.slave bus
);

  localparam int              CNT_W    = calc_cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  calc_state_e      r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_sum;
  logic             r_c;
  logic [CNT_W-1:0] r_cnt;

  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_sum;
  logic             r_out_cout;
  logic             r_out_ovf;

  logic             w_s;
  logic             w_co;
  logic [WIDTH-1:0] w_sum_next;

  serial_bit_cell u_cell (
    .i_a  (r_sa[0]),
    .i_b  (r_sb[0]),
    .i_c  (r_c),
    .o_s  (w_s),
    .o_co (w_co)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at [0].
  assign w_sum_next = {w_s, r_sum[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_sa        <= '0;
      r_sb        <= '0;
      r_sum       <= '0;
      r_c         <= 1'b0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_cout  <= 1'b0;
      r_out_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_in_ready <= 1'b1;
          if (bus.in_valid && r_in_ready) begin
            r_sa       <= bus.in_a;
`ifdef SERIAL_SUB_EN
            // A - B computed as A + ~B + 1
            r_sb       <= bus.in_sub ? ~bus.in_b : bus.in_b;
            r_c        <= bus.in_sub;
`else
            r_sb       <= bus.in_b;
            r_c        <= 1'b0;
`endif
            r_sum      <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end

        RUN: begin
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          r_sum <= w_sum_next;
          r_c   <= w_co;
          if (r_cnt == CNT_LAST) begin
            // r_c here is still the carry into the MSB
            r_out_sum   <= w_sum_next;
            r_out_cout  <= w_co;
            r_out_ovf   <= r_c ^ w_co;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            // Ready again right away so back-to-back ops take WIDTH+2 cycles
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end

        default: begin
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_out_sum;
  assign bus.out_cout  = r_out_cout;
  assign bus.out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// ---------------------------------------------------------------------------
// tb_serial_add_sequencer
// Bench for serial_add_sequencer at WIDTH=8 and WIDTH=13. Directed vector
// table, backpressure and mid-run reset sequences, then random operands
// against an arithmetic reference model with random result stalls.
// Optional feature macro: SERIAL_SUB_EN
// ---------------------------------------------------------------------------
module tb_serial_add_sequencer;
  import calc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_add_sequencer_if #(.WIDTH(8))  if8 ();
  serial_add_sequencer_if #(.WIDTH(13)) if13 ();

  serial_add_sequencer #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8.slave));
  serial_add_sequencer #(.WIDTH(13)) dut13 (.clk(clk), .rst(rst), .bus(if13.slave));

  // One set of drive variables steered to the selected instance.
  logic        sel;
  logic        drv_valid;
  logic        drv_ordy;
  logic [31:0] drv_a;
  logic [31:0] drv_b;
`ifdef SERIAL_SUB_EN
  logic        drv_sub;
  assign if8.in_sub  = drv_sub;
  assign if13.in_sub = drv_sub;
`endif

  assign if8.in_valid   = drv_valid & ~sel;
  assign if8.in_a       = drv_a[7:0];
  assign if8.in_b       = drv_b[7:0];
  assign if8.out_ready  = drv_ordy & ~sel;
  assign if13.in_valid  = drv_valid & sel;
  assign if13.in_a      = drv_a[12:0];
  assign if13.in_b      = drv_b[12:0];
  assign if13.out_ready = drv_ordy & sel;

  logic        m_rdy, m_vld, m_cout, m_ovf;
  logic [31:0] m_sum;
  assign m_rdy  = sel ? if13.in_ready  : if8.in_ready;
  assign m_vld  = sel ? if13.out_valid : if8.out_valid;
  assign m_cout = sel ? if13.out_cout  : if8.out_cout;
  assign m_ovf  = sel ? if13.out_ovf   : if8.out_ovf;
  assign m_sum  = sel ? {19'd0, if13.out_sum} : {24'd0, if8.out_sum};

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain two's-complement arithmetic on w-bit values.
  task automatic model(input int w, input logic [31:0] a, input logic [31:0] b,
                       input logic sub, output logic [31:0] s,
                       output logic co, output logic ov);
    logic [63:0] mask, aa, bb, full;
    mask = (64'd1 << w) - 64'd1;
    aa   = {32'd0, a} & mask;
    bb   = sub ? (~{32'd0, b} & mask) : ({32'd0, b} & mask);
    full = aa + bb + {63'd0, sub};
    s    = full[31:0] & mask[31:0];
    co   = full[w];
    ov   = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
  endtask

  // Runs one operation on the selected instance. Called and returns at a
  // negedge. pre_rdy holds out_ready high from the start; otherwise the
  // result is stalled for 'stall' cycles (optionally with a spurious in_valid).
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                       input bit pre_rdy, input int stall, input bit poke,
                       output logic [31:0] s, output logic co, output logic ov);
    int guard;
    int lat;
    int w;
    bit stable;
    w = sel ? 13 : 8;
    guard = 0;
    while (m_rdy !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: in_ready=%b expected=1", m_rdy);
    end
    drv_a     = a;
    drv_b     = b;
`ifdef SERIAL_SUB_EN
    drv_sub   = sub;
`endif
    drv_valid = 1'b1;
    drv_ordy  = pre_rdy;
    @(negedge clk);
    drv_valid = 1'b0;
    lat = 0;
    while (m_vld !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    // Edges after the accept edge; with the accept edge that is WIDTH+1.
    chk("latency", lat, w);
    s  = m_sum;
    co = m_cout;
    ov = m_ovf;
    if (!pre_rdy) begin
      stable = 1'b1;
      for (int k = 0; k < stall; k++) begin
        if (poke) begin
          drv_valid = 1'b1;
          drv_a     = ~a;
          drv_b     = ~b;
        end
        @(negedge clk);
        if (m_vld !== 1'b1 || m_rdy !== 1'b0 || m_sum !== s ||
            m_cout !== co || m_ovf !== ov)
          stable = 1'b0;
      end
      drv_valid = 1'b0;
      if (stall > 0) chk("stall_stable", {31'd0, stable}, 32'd1);
      drv_ordy = 1'b1;
    end
    @(negedge clk);
    chk("post_out_valid", {31'd0, m_vld}, 32'd0);
    chk("post_in_ready", {31'd0, m_rdy}, 32'd1);
    chk("post_hold_sum", m_sum, s);
    drv_ordy = 1'b0;
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] s, es, ra, rb;
    logic        co, ov, eco, eov, rsub;
    bit          saw;
    int          w;

    vecs.push_back('{8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0});
    vecs.push_back('{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1});
    vecs.push_back('{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1});
    vecs.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0});
`ifdef SERIAL_SUB_EN
    vecs.push_back('{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0});
    vecs.push_back('{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1});
    vecs.push_back('{8'h10, 8'h10, 1'b1, 8'h00, 1'b1, 1'b0});
`endif

    sel       = 1'b0;
    drv_valid = 1'b0;
    drv_ordy  = 1'b0;
    drv_a     = '0;
    drv_b     = '0;
`ifdef SERIAL_SUB_EN
    drv_sub   = 1'b0;
`endif
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready8",  {31'd0, if8.in_ready},   32'd0);
    chk("rst_out_valid8", {31'd0, if8.out_valid},  32'd0);
    chk("rst_sum8",       {24'd0, if8.out_sum},    32'd0);
    chk("rst_cout8",      {31'd0, if8.out_cout},   32'd0);
    chk("rst_ovf8",       {31'd0, if8.out_ovf},    32'd0);
    chk("rst_in_ready13", {31'd0, if13.in_ready},  32'd0);
    chk("rst_sum13",      {19'd0, if13.out_sum},   32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready8", {31'd0, if8.in_ready}, 32'd1);

    // Backpressure with a spurious in_valid while the result is held.
    do_op(32'h3C, 32'h05, 1'b0, 1'b0, 5, 1'b1, s, co, ov);
    chk("bp_sum",  s, 32'h41);
    chk("bp_cout", {31'd0, co}, 32'd0);
    chk("bp_ovf",  {31'd0, ov}, 32'd0);

    foreach (vecs[i]) begin
      do_op({24'd0, vecs[i].a}, {24'd0, vecs[i].b}, vecs[i].sub,
            bit'(i % 2), 0, 1'b0, s, co, ov);
      chk($sformatf("vec%0d_sum", i),  s, {24'd0, vecs[i].s});
      chk($sformatf("vec%0d_cout", i), {31'd0, co}, {31'd0, vecs[i].co});
      chk($sformatf("vec%0d_ovf", i),  {31'd0, ov}, {31'd0, vecs[i].ov});
    end

    // Reset in the middle of RUN aborts the operation.
    while (m_rdy !== 1'b1) @(negedge clk);
    drv_a     = 32'hFF;
    drv_b     = 32'hFF;
    drv_valid = 1'b1;
    drv_ordy  = 1'b1;
    @(negedge clk);
    drv_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", {31'd0, if8.in_ready}, 32'd0);
    rst = 1'b0;
    saw = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (if8.out_valid !== 1'b0) saw = 1'b1;
    end
    drv_ordy = 1'b0;
    chk("midrst_no_valid", {31'd0, saw}, 32'd0);
    chk("midrst_state", 32'(dut8.r_state), 32'(IDLE));
    chk("midrst_in_ready_after", {31'd0, if8.in_ready}, 32'd1);
    chk("midrst_sum_cleared", {24'd0, if8.out_sum}, 32'd0);
    do_op(32'h10, 32'h20, 1'b0, 1'b0, 0, 1'b0, s, co, ov);
    chk("after_rst_sum", s, 32'h30);

    // Random operands at both widths.
    for (int pass = 0; pass < 2; pass++) begin
      sel = pass[0];
      w   = sel ? 13 : 8;
      @(negedge clk);
      for (int i = 0; i < 1000; i++) begin
        ra = $urandom;
        rb = $urandom;
        if ((i % 8) == 0) ra = 32'hFFFF_FFFF;
        if ((i % 8) == 1) rb = 32'h0000_0001 << (w - 1);
        ra = ra & ((32'd1 << w) - 32'd1);
        rb = rb & ((32'd1 << w) - 32'd1);
`ifdef SERIAL_SUB_EN
        rsub = 1'($urandom_range(0, 1));
`else
        rsub = 1'b0;
`endif
        model(w, ra, rb, rsub, es, eco, eov);
        do_op(ra, rb, rsub, bit'($urandom_range(0, 1)), $urandom_range(0, 3),
              bit'($urandom_range(0, 1)), s, co, ov);
        chk($sformatf("rnd_w%0d_sum a=%h b=%h sub=%b", w, ra, rb, rsub), s, es);
        chk($sformatf("rnd_w%0d_cout a=%h b=%h sub=%b", w, ra, rb, rsub),
            {31'd0, co}, {31'd0, eco});
        chk($sformatf("rnd_w%0d_ovf a=%h b=%h sub=%b", w, ra, rb, rsub),
            {31'd0, ov}, {31'd0, eov});
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
